hazard_control_unit: RTL

// - Produces the stall / invalid_ID control consumed by the ID/EX pipeline register, plus IF-side squash.
// - Tracks in-flight register writers (EX, MEM, WB) in an internal scoreboard.
// - Stalls ID on RAW hazards and runs a branch-flush FSM on taken branches.
// - Sits beside the decoder; sole owner of pipeline bubble/flush policy for the RV32E core.

---
 rtl/hazard_control_unit_if.sv | 32 +++
 rtl/hazard_control_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_control_unit_if.sv
// Pipeline-facing bundle of the hazard control unit: ID/EX operand info in,
// stall/squash control and performance counters out.
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       rs1_ID;
    logic [3:0]       rs2_ID;
    logic             rs1_used_ID;
    logic             rs2_used_ID;
    logic [3:0]       rd_EX;
    logic             regfile_we_EX;
    logic             is_load_EX;
    logic             invalid_EX;
    logic             branch_taken_EX;
    logic             stall;
    logic             invalid_ID;
    logic             flush_IF;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        output rd_EX, regfile_we_EX, is_load_EX, invalid_EX, branch_taken_EX,
        input  stall, invalid_ID, flush_IF, stall_count, flush_count
    );

    modport slave (
        input  rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
        input  rd_EX, regfile_we_EX, is_load_EX, invalid_EX, branch_taken_EX,
        output stall, invalid_ID, flush_IF, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit.sv
// RAW-stall and taken-branch flush control for the RV32E pipeline.
// Define FORWARDING_EN to stall only on load-use (ALU results are forwarded).
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_control_unit_if.slave hz
);
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       is_load;
    } slot_t;

    typedef enum logic {RUN, FLUSH} state_t;

`ifdef FORWARDING_EN
    localparam int  NCHK      = 2;
    localparam bit  LOAD_ONLY = 1'b1;
`else
    localparam int  NCHK      = 3;
    localparam bit  LOAD_ONLY = 1'b0;
`endif
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 2);

    slot_t            prod [3];
    slot_t            mem_reg;
    slot_t            wb_reg;
    logic [2:0]       slot_hit;
    logic             hazard;
    state_t           state_reg, state_next;
    logic [2:0]       cnt_reg, cnt_next;
    logic             stall, invalid_id, flush_if, flush_evt;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;

    assign prod[0] = '{valid:   hz.regfile_we_EX & ~hz.invalid_EX & (hz.rd_EX != 4'd0),
                       rd:      hz.rd_EX,
                       is_load: hz.is_load_EX};
    assign prod[1] = mem_reg;
    assign prod[2] = wb_reg;

    // Slot gi is only considered when it is still ahead of the forwarding network.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_match
            logic rs1_hit, rs2_hit;
            assign rs1_hit = hz.rs1_used_ID && (hz.rs1_ID != 4'd0) && (hz.rs1_ID == prod[gi].rd);
            assign rs2_hit = hz.rs2_used_ID && (hz.rs2_ID != 4'd0) && (hz.rs2_ID == prod[gi].rd);
            assign slot_hit[gi] = (gi < NCHK) && prod[gi].valid &&
                                  (!LOAD_ONLY || prod[gi].is_load) && (rs1_hit || rs2_hit);
        end
    endgenerate

    assign hazard = |slot_hit;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        invalid_id = 1'b0;
        flush_if   = 1'b0;
        flush_evt  = 1'b0;
        if (!rst_n) begin
            invalid_id = 1'b1;
            flush_if   = 1'b1;
            state_next = RUN;
            cnt_next   = 3'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hz.branch_taken_EX && !hz.invalid_EX) begin
                        flush_if   = 1'b1;
                        invalid_id = 1'b1;
                        flush_evt  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next = FLUSH;
                            cnt_next   = CNT_INIT;
                        end
                    end else if (hazard) begin
                        stall = 1'b1;
                    end
                end
                FLUSH: begin
                    invalid_id = 1'b1;
                    if (cnt_reg == 3'd0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt_reg - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            cnt_reg         <= 3'd0;
            mem_reg         <= '0;
            wb_reg          <= '0;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mem_reg   <= prod[0];
            wb_reg    <= mem_reg;
            if (stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (flush_evt && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign hz.stall       = stall;
    assign hz.invalid_ID  = invalid_id;
    assign hz.flush_IF    = flush_if;
    assign hz.stall_count = stall_count_reg;
    assign hz.flush_count = flush_count_reg;
endmodule
